// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: shared FSM encodings and framing constants for the serial frame receiver
package serial_frame_rx_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/serial_frame_rx_fifo2.sv
// rx_fifo2: two-entry FIFO whose head entry is itself the registered output word
module rx_fifo2
   import serial_frame_rx_pkg::*;
#(
   parameter int Len = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic [Len-1:0] din,
   input  logic           pop,
   output logic [Len-1:0] head,
   output logic           full,
   output logic           empty,
   output logic           overflow
);
   logic [Len-1:0] tail;
   logic [1:0] count;
   logic do_pop;
   assign full = count == 2'(FIFO_DEPTH);
   assign empty = count == 2'd0;
   assign do_pop = pop & ~empty;
   // head keeps its last value after draining so data_out holds while invalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push & full & ~do_pop;
         if (do_pop && full) head <= tail;
         if (push && (empty || (count == 2'd1 && do_pop))) head <= din;
         if (push && ((count == 2'd1 && !do_pop) || (full && do_pop))) tail <= din;
         count <= count + {1'b0, push & ~(full & ~do_pop)} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: frames a strobed MSB-first serial bitstream into words and buffers them
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int Len = 8,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sin,
   input  logic           sin_en,
   output logic [Len-1:0] data_out,
   output logic           data_valid,
   input  logic           data_ready,
   output logic           frame_err,
   output logic           overflow,
   output logic           busy
);
   localparam int CW = $clog2(Len);
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [Len-1:0] shreg;
   logic perr, push_q, stop_ok, stop_bad, empty, full;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      stop_ok = 1'b0;
      stop_bad = 1'b0;
      if (sin_en) begin
         case (state)
            S_IDLE: state_nx = (sin == START_BIT) ? S_DATA : S_IDLE;
            S_DATA: state_nx = (cnt == CW'(Len - 1)) ? (PARITY_EN ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: state_nx = S_STOP;
            default: begin
               state_nx = S_IDLE;
               stop_ok = (sin == STOP_BIT) & ~perr;
               stop_bad = ~stop_ok;
            end
         endcase
      end
   end
   // shreg is untouched in IDLE, so the FIFO can still take it on the edge after the stop bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         shreg <= '0;
         perr <= 1'b0;
         push_q <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         push_q <= stop_ok;
         frame_err <= stop_bad;
         if (sin_en) begin
            case (state)
               S_IDLE: begin
                  cnt <= '0;
                  perr <= 1'b0;
               end
               S_DATA: begin
                  shreg <= {shreg[Len-2:0], sin};
                  cnt <= cnt + 1'b1;
               end
               S_PARITY: perr <= ^{shreg, sin};
               default: ;
            endcase
         end
      end
   end
   rx_fifo2 #(.Len(Len)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push_q),
      .din(shreg),
      .pop(data_ready),
      .head(data_out),
      .full(full),
      .empty(empty),
      .overflow(overflow)
   );
   assign data_valid = ~empty;
   assign busy = state != S_IDLE;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx with and without parity
module tb_serial_frame_rx;
   logic clk = 1'b0, rst = 1'b1, sin = 1'b1, en_a = 1'b0, en_b = 1'b0;
   logic ready_a = 1'b1, ready_b = 1'b1;
   logic [7:0] dout_a, dout_b;
   logic valid_a, valid_b, ferr_a, ferr_b, ovf_a, ovf_b, busy_a, busy_b;
   int n_chk = 0, n_fail = 0, err_a = 0, err_b = 0, ovf_cnt = 0;
   logic [7:0] q_a[$], q_b[$];
   always #5 clk = ~clk;
   serial_frame_rx #(.Len(8), .PARITY_EN(1'b0)) dut_a (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(en_a), .data_out(dout_a), .data_valid(valid_a),
      .data_ready(ready_a), .frame_err(ferr_a), .overflow(ovf_a), .busy(busy_a));
   serial_frame_rx #(.Len(8), .PARITY_EN(1'b1)) dut_b (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(en_b), .data_out(dout_b), .data_valid(valid_b),
      .data_ready(ready_b), .frame_err(ferr_b), .overflow(ovf_b), .busy(busy_b));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (ferr_a) err_a++;
      if (ferr_b) err_b++;
      if (ovf_a) ovf_cnt++;
      if (valid_a && ready_a) begin
         if (q_a.size() == 0) chk("unexpected_word_a", {24'd0, dout_a}, 32'hxxxx);
         else chk("word_a", {24'd0, dout_a}, {24'd0, q_a.pop_front()});
      end
      if (valid_b && ready_b) begin
         if (q_b.size() == 0) chk("unexpected_word_b", {24'd0, dout_b}, 32'hxxxx);
         else chk("word_b", {24'd0, dout_b}, {24'd0, q_b.pop_front()});
      end
   end
   task automatic send(input logic [10:0] bits, input int n, input bit sel_b, input bit gap);
      for (int i = n - 1; i >= 0; i--) begin
         sin = bits[i];
         if (sel_b) en_b = 1'b1; else en_a = 1'b1;
         @(posedge clk); #1;
         en_a = 1'b0;
         en_b = 1'b0;
         if (gap) begin
            sin = ~sin;
            @(posedge clk); #1;
         end
      end
      sin = 1'b1;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      int e0, o0, t;
      #1;
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_dout", dout_a, 8'h00);
      idle(3);
      rst = 1'b0;
      idle(2);
      // 1: continuous strobe, check one-clock push latency
      q_a.push_back(8'hA5);
      e0 = err_a;
      send({1'b0, 8'hA5, 1'b1}, 10, 1'b0, 1'b0);
      chk("t1_valid_at_stop", valid_a, 1'b0);
      idle(1);
      chk("t1_valid_next", valid_a, 1'b1);
      chk("t1_dout", dout_a, 8'hA5);
      idle(3);
      chk("t1_no_err", err_a - e0, 0);
      // 2: strobe gaps with sin wiggling
      q_a.push_back(8'hA5);
      send({1'b0, 8'hA5, 1'b1}, 10, 1'b0, 1'b1);
      idle(1);
      chk("t2_dout", dout_a, 8'hA5);
      idle(3);
      chk("t2_no_err", err_a - e0, 0);
      // 3: bad stop bit, then a good frame
      send({1'b0, 8'h3C, 1'b0}, 10, 1'b0, 1'b0);
      idle(3);
      chk("t3_err_pulse", err_a - e0, 1);
      chk("t3_no_valid", valid_a, 1'b0);
      q_a.push_back(8'h3D);
      send({1'b0, 8'h3D, 1'b1}, 10, 1'b0, 1'b0);
      idle(3);
      chk("t3_err_once", err_a - e0, 1);
      // 4: overflow on third word with consumer stalled
      ready_a = 1'b0;
      o0 = ovf_cnt;
      q_a.push_back(8'h11);
      q_a.push_back(8'h22);
      send({1'b0, 8'h11, 1'b1}, 10, 1'b0, 1'b0);
      send({1'b0, 8'h22, 1'b1}, 10, 1'b0, 1'b0);
      send({1'b0, 8'h33, 1'b1}, 10, 1'b0, 1'b0);
      idle(4);
      chk("t4_overflow", ovf_cnt - o0, 1);
      chk("t4_head", dout_a, 8'h11);
      chk("t4_valid", valid_a, 1'b1);
      chk("t4_no_err", err_a - e0, 1);
      ready_a = 1'b1;
      t = 0;
      while (q_a.size() != 0 && t < 20) begin idle(1); t++; end
      chk("t4_drained", q_a.size(), 0);
      chk("t4_empty", valid_a, 1'b0);
      chk("t4_hold_dout", dout_a, 8'h22);
      // 5: even parity
      q_b.push_back(8'h07);
      send({1'b0, 8'h07, 1'b1, 1'b1}, 11, 1'b1, 1'b0);
      idle(3);
      chk("t5_good_no_err", err_b, 0);
      send({1'b0, 8'h07, 1'b0, 1'b1}, 11, 1'b1, 1'b0);
      idle(3);
      chk("t5_bad_err", err_b, 1);
      chk("t5_no_valid", valid_b, 1'b0);
      // 6: reset mid-frame flushes buffer and partial word
      ready_a = 1'b0;
      send({1'b0, 8'h44, 1'b1}, 10, 1'b0, 1'b0);
      idle(2);
      chk("t6_pre_valid", valid_a, 1'b1);
      send({6'd0, 1'b0, 4'b1010}, 5, 1'b0, 1'b0);
      chk("t6_pre_busy", busy_a, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", busy_a, 1'b0);
      chk("t6_rst_valid", valid_a, 1'b0);
      idle(2);
      e0 = err_a;
      o0 = ovf_cnt;
      rst = 1'b0;
      ready_a = 1'b1;
      idle(3);
      chk("t6_no_pulse", (err_a - e0) + (ovf_cnt - o0), 0);
      q_a.push_back(8'hFF);
      send({1'b0, 8'hFF, 1'b1}, 10, 1'b0, 1'b0);
      idle(1);
      chk("t6_dout", dout_a, 8'hFF);
      t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < 20) begin idle(1); t++; end
      chk("final_q_a", q_a.size(), 0);
      chk("final_q_b", q_b.size(), 0);
      chk("t6_no_err", err_a - e0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
